fp_comp_ctrl: RTL and testbench

Request-side controller for the FP comparator. Accepts a compare request (two operands plus predicate opcode) on a valid/ready handshake, drives the comparator's operand and `act` inputs, holds them stable for the comparator's latency, and samples `eq`/`great`/`less`/`done`/`inv`. It returns a predicate bit, or a selected operand, on a valid/ready response channel. It sits between the FPU instruction decode/issue stage and the comparator instance.

---
 rtl/fp_comp_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fp_comp_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_comp_ctrl.sv
// Request-side controller for the FP comparator: handshake in, hold operands, sample flags, respond.
// Optional MIN/MAX operand select is enabled by defining FP_COMP_CTRL_MINMAX_EN.
module fp_comp_ctrl #(
    parameter int W   = 32,
    parameter int LAT = 2,
    parameter int TMO = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_bit,
    output logic [W-1:0] rsp_val,
    output logic         rsp_inv,
    output logic         rsp_err,
    output logic [W-1:0] cmp_in1,
    output logic [W-1:0] cmp_in2,
    output logic         cmp_act,
    input  logic         cmp_eq,
    input  logic         cmp_great,
    input  logic         cmp_less,
    input  logic         cmp_done,
    input  logic         cmp_inv
);

    localparam int CW = $clog2(TMO + 1);
    localparam logic [CW-1:0] LAT_M1 = CW'(LAT - 1);
    localparam logic [CW-1:0] TMO_M1 = CW'(TMO - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  in1_q, in1_d, in2_q, in2_d;
    logic          req_ready_q, req_ready_d;
    logic          cmp_act_q, cmp_act_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_bit_q, rsp_bit_d;
    logic [W-1:0]  rsp_val_q, rsp_val_d;
    logic          rsp_inv_q, rsp_inv_d;
    logic          rsp_err_q, rsp_err_d;

    logic          f_eq, f_lt, f_gt;
    logic          cap_bit, cap_err;
    logic [W-1:0]  cap_val;

`ifdef FP_COMP_CTRL_MINMAX_EN
    localparam logic [W-1:0] QNAN = W'(32'h7FC0_0000);
    logic unord;
`endif

    // Conflicting flags resolve with priority eq > less > great.
    always_comb begin
        f_eq    = cmp_eq;
        f_lt    = cmp_less & ~cmp_eq;
        f_gt    = cmp_great & ~cmp_eq & ~cmp_less;
        cap_bit = 1'b0;
        cap_val = '0;
        cap_err = 1'b0;
`ifdef FP_COMP_CTRL_MINMAX_EN
        unord   = ~(cmp_eq | cmp_less | cmp_great);
`endif
        case (op_q)
            3'd0: cap_bit = f_eq;
            3'd1: cap_bit = ~f_eq;
            3'd2: cap_bit = f_lt;
            3'd3: cap_bit = f_lt | f_eq;
            3'd4: cap_bit = f_gt;
            3'd5: cap_bit = f_gt | f_eq;
`ifdef FP_COMP_CTRL_MINMAX_EN
            3'd6: begin
                cap_bit = f_gt;
                cap_val = unord ? QNAN : (f_gt ? in2_q : in1_q);
            end
            3'd7: begin
                cap_bit = f_gt;
                cap_val = unord ? QNAN : ((f_gt | f_eq) ? in1_q : in2_q);
            end
`else
            default: cap_err = 1'b1;
`endif
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        rsp_bit_d = rsp_bit_q;
        rsp_val_d = rsp_val_q;
        rsp_inv_d = rsp_inv_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d    = req_op;
                    in1_d   = req_a;
                    in2_d   = req_b;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q >= LAT_M1 && cmp_done) begin
                    rsp_bit_d = cap_bit;
                    rsp_val_d = cap_val;
                    rsp_inv_d = cmp_inv;
                    rsp_err_d = cap_err;
                    state_d   = S_RESP;
                end else if (cnt_q == TMO_M1) begin
                    rsp_bit_d = 1'b0;
                    rsp_val_d = '0;
                    rsp_inv_d = 1'b0;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_bit_d = 1'b0;
                    rsp_val_d = '0;
                    rsp_inv_d = 1'b0;
                    rsp_err_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
        cmp_act_d   = (state_d == S_WAIT);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            req_ready_q <= 1'b0;
            cmp_act_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_bit_q   <= 1'b0;
            rsp_val_q   <= '0;
            rsp_inv_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            req_ready_q <= req_ready_d;
            cmp_act_q   <= cmp_act_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_bit_q   <= rsp_bit_d;
            rsp_val_q   <= rsp_val_d;
            rsp_inv_q   <= rsp_inv_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign cmp_act   = cmp_act_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_bit   = rsp_bit_q;
    assign rsp_val   = rsp_val_q;
    assign rsp_inv   = rsp_inv_q;
    assign rsp_err   = rsp_err_q;
    assign cmp_in1   = in1_q;
    assign cmp_in2   = in2_q;

endmodule

// File: tb/tb_fp_comp_ctrl.sv
// Directed bench for fp_comp_ctrl: vector table of single compares plus hand-written
// reset, timeout, back-pressure and mid-transaction reset sequences.
module tb_fp_comp_ctrl;

    localparam int LAT = 2;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        rsp_valid, rsp_ready, rsp_bit, rsp_inv, rsp_err;
    logic [31:0] rsp_val, cmp_in1, cmp_in2;
    logic        cmp_act, cmp_eq, cmp_great, cmp_less, cmp_done, cmp_inv;

    logic m_eq, m_gt, m_lt, m_inv, m_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Comparator stand-in: flags are static, done only while the controller drives act.
    assign cmp_eq    = m_eq;
    assign cmp_great = m_gt;
    assign cmp_less  = m_lt;
    assign cmp_inv   = m_inv;
    assign cmp_done  = cmp_act & m_done;

    fp_comp_ctrl #(.W(32), .LAT(LAT), .TMO(TMO)) dut (
        .clk(clk), .rst(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bit(rsp_bit),
        .rsp_val(rsp_val), .rsp_inv(rsp_inv), .rsp_err(rsp_err),
        .cmp_in1(cmp_in1), .cmp_in2(cmp_in2), .cmp_act(cmp_act),
        .cmp_eq(cmp_eq), .cmp_great(cmp_great), .cmp_less(cmp_less),
        .cmp_done(cmp_done), .cmp_inv(cmp_inv)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        eq, gt, lt, inv, done;
        logic        ebit;
        logic [31:0] eval;
        logic        eerr, einv;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        int exp_cyc;
        exp_cyc   = v.done ? LAT + 1 : TMO + 1;
        m_eq = v.eq; m_gt = v.gt; m_lt = v.lt; m_inv = v.inv; m_done = v.done;
        rsp_ready = 1'b1;
        chk($sformatf("v%0d req_ready_pre", idx), req_ready, 1);
        req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
        tick();
        req_valid = 1'b0;
        cyc = 1;
        chk($sformatf("v%0d cmp_act", idx), cmp_act, 1);
        chk($sformatf("v%0d cmp_in1", idx), cmp_in1, v.a);
        chk($sformatf("v%0d cmp_in2", idx), cmp_in2, v.b);
        while (!rsp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk($sformatf("v%0d latency", idx), cyc, exp_cyc);
        chk($sformatf("v%0d rsp_bit", idx), rsp_bit, v.ebit);
        chk($sformatf("v%0d rsp_val", idx), rsp_val, v.eval);
        chk($sformatf("v%0d rsp_err", idx), rsp_err, v.eerr);
        chk($sformatf("v%0d rsp_inv", idx), rsp_inv, v.einv);
        tick();
        chk($sformatf("v%0d req_ready_post", idx), req_ready, 1);
        chk($sformatf("v%0d rsp_valid_post", idx), rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        //            op    a             b             eq gt lt inv dn  bit val           err inv
        vecs[0]  = '{3'd2, 32'h3F800000, 32'h40000000, 0, 0, 1, 0, 1,  1, 32'h0,        0, 0};
        vecs[1]  = '{3'd1, 32'h7FC00000, 32'h3F800000, 0, 0, 0, 1, 1,  1, 32'h0,        0, 1};
        vecs[2]  = '{3'd0, 32'h7FC00000, 32'h3F800000, 0, 0, 0, 1, 1,  0, 32'h0,        0, 1};
        vecs[3]  = '{3'd0, 32'h40400000, 32'h40400000, 1, 0, 0, 0, 1,  1, 32'h0,        0, 0};
        vecs[4]  = '{3'd5, 32'h40800000, 32'h40400000, 0, 1, 0, 0, 1,  1, 32'h0,        0, 0};
        vecs[5]  = '{3'd3, 32'h40800000, 32'h40400000, 0, 1, 0, 0, 1,  0, 32'h0,        0, 0};
        vecs[6]  = '{3'd4, 32'h3F800000, 32'h40000000, 0, 0, 1, 0, 1,  0, 32'h0,        0, 0};
        vecs[7]  = '{3'd3, 32'h40400000, 32'h40400000, 1, 0, 0, 0, 1,  1, 32'h0,        0, 0};
        vecs[8]  = '{3'd2, 32'h11111111, 32'h22222222, 1, 1, 1, 0, 1,  0, 32'h0,        0, 0};
        vecs[9]  = '{3'd4, 32'h11111111, 32'h22222222, 0, 1, 1, 0, 1,  0, 32'h0,        0, 0};
        vecs[10] = '{3'd2, 32'h12345678, 32'h9ABCDEF0, 0, 0, 1, 1, 0,  0, 32'h0,        1, 0};
`ifdef FP_COMP_CTRL_MINMAX_EN
        vecs[11] = '{3'd7, 32'hC0000000, 32'h3F800000, 0, 0, 1, 0, 1,  0, 32'h3F800000, 0, 0};
        vecs[12] = '{3'd6, 32'h7FC00000, 32'h3F800000, 0, 0, 0, 1, 1,  0, 32'h7FC00000, 0, 1};
`else
        vecs[11] = '{3'd7, 32'hC0000000, 32'h3F800000, 0, 0, 1, 0, 1,  0, 32'h0,        1, 0};
        vecs[12] = '{3'd6, 32'h7FC00000, 32'h3F800000, 0, 0, 0, 1, 1,  0, 32'h0,        1, 1};
`endif

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b0;
        m_eq = 0; m_gt = 0; m_lt = 0; m_inv = 0; m_done = 1;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst%0d req_ready", i), req_ready, 0);
            chk($sformatf("rst%0d outs", i),
                {rsp_valid, rsp_bit, rsp_inv, rsp_err, cmp_act}, 0);
            chk($sformatf("rst%0d vals", i), rsp_val | cmp_in1 | cmp_in2, 0);
        end
        rst_n = 1'b1;
        tick();
        chk("release req_ready", req_ready, 1);
        chk("release rsp_valid", rsp_valid, 0);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

`ifdef FP_COMP_CTRL_MINMAX_EN
        begin
            vec_t v;
            v = '{3'd6, 32'hC0000000, 32'h3F800000, 0, 0, 1, 0, 1, 0, 32'hC0000000, 0, 0};
            run_vec(20, v);
            v = '{3'd7, 32'h40000000, 32'h3F800000, 0, 1, 0, 0, 1, 1, 32'h40000000, 0, 0};
            run_vec(21, v);
        end
`endif

        // Back-pressure: response held, a new request ignored.
        m_eq = 0; m_gt = 1; m_lt = 0; m_inv = 0; m_done = 1;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_op = 3'd4; req_a = 32'hAAAA0001; req_b = 32'h5555_0002;
        tick();
        req_a = 32'hDEADBEEF; req_b = 32'hFEEDF00D; req_op = 3'd0;
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("bp latency", cyc, LAT + 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp%0d rsp_valid", i), rsp_valid, 1);
            chk($sformatf("bp%0d rsp_bit", i), rsp_bit, 1);
            chk($sformatf("bp%0d req_ready", i), req_ready, 0);
            chk($sformatf("bp%0d cmp_in1", i), cmp_in1, 32'hAAAA0001);
            chk($sformatf("bp%0d cmp_in2", i), cmp_in2, 32'h55550002);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("bp release req_ready", req_ready, 1);
        chk("bp release rsp_valid", rsp_valid, 0);
        chk("bp ignored cmp_in1", cmp_in1, 32'hAAAA0001);

        // Reset in the middle of WAIT drops the transaction.
        m_done = 1;
        req_valid = 1'b1; req_op = 3'd2; req_a = 32'h1; req_b = 32'h2;
        tick();
        req_valid = 1'b0;
        chk("mid cmp_act", cmp_act, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid rst cmp_act", cmp_act, 0);
        chk("mid rst rsp_valid", rsp_valid, 0);
        chk("mid rst cmp_in1", cmp_in1, 0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                seen = seen | rsp_valid | cmp_act;
            end
            chk("mid no response", seen, 0);
            chk("mid req_ready", req_ready, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
